// File: rtl/mvm_pkg.sv
// mvm_pkg: default sizing and signed datapath types for the MVM datapath.
// Sizing follows `MVM_N / `MVM_N_SIZE from config.sv; stand-alone defaults apply when absent.
`ifndef MVM_N
`define MVM_N 8
`endif
`ifndef MVM_N_SIZE
`define MVM_N_SIZE ($clog2(`MVM_N) + 1)
`endif

package mvm_pkg;

  localparam int N_DEF  = `MVM_N;
  localparam int W_DEF  = 16;
  localparam int CW_DEF = `MVM_N_SIZE;
  localparam int AW_DEF = 2 * W_DEF + $clog2(N_DEF);

  typedef logic signed [W_DEF-1:0]    data_t;
  typedef logic signed [2*W_DEF-1:0]  prod_t;
  typedef logic signed [AW_DEF-1:0]   acc_t;
  typedef data_t [N_DEF-1:0]          row_t;

endpackage

// File: rtl/mvm_mac_lane.sv
// mvm_mac_lane: one output column -- registered product and its accumulator.
module mvm_mac_lane
   import mvm_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int AW = AW_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 calc,
   input  logic                 up_sum,
   input  logic                 clr,
   input  logic signed [W-1:0]  x_q,
   input  logic signed [W-1:0]  w_q,
   output logic signed [AW-1:0] acc
);

   logic signed [2*W-1:0] prod_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q <= '0;
         acc    <= '0;
      end else begin
         if (calc)
            prod_q <= (2*W)'(x_q) * (2*W)'(w_q);
         // a new MVM's clear takes priority over a stray accumulate
         if (clr)
            acc <= '0;
         else if (up_sum)
            acc <= acc + AW'(prod_q);
      end
   end

endmodule

// File: rtl/mvm_datapath.sv
// mvm_datapath: x buffer, N x N weight store, N MAC lanes and output register for y = x * W.
// Optional MVM_ZERO_SKIP_EN drives skip for zero input elements; otherwise skip is tied low.
module mvm_datapath
   import mvm_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int W  = W_DEF,
   parameter int CW = $clog2(N) + 1,
   parameter int AW = 2 * W + $clog2(N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  prog_wt,
   input  logic [$clog2(N)-1:0]  wt_addr,
   input  logic [N*W-1:0]        wt_row,
   input  logic                  get_ready,
   input  logic                  fetch,
   input  logic                  rd_en,
   input  logic                  calc,
   input  logic                  up_sum,
   input  logic [CW-1:0]         counter,
   input  logic                  mvm_done,
   output logic                  skip,
   input  logic [N*W-1:0]        in_vec,
   output logic [N*AW-1:0]       out_vec,
   output logic                  out_valid
);

   localparam int IW = $clog2(N);
   localparam logic [CW-1:0] N_CNT = CW'(N);

   logic [N*W-1:0]      wmem [N];
   logic [N*W-1:0]      xbuf;
   logic [N*W-1:0]      w_q;
   logic signed [W-1:0] x_q;
   logic [IW-1:0]       idx_q;
   logic [IW-1:0]       cidx;
   logic                cnt_ok;
   logic signed [W-1:0] x_sel;
   logic [N*AW-1:0]     acc_flat;

   assign cnt_ok = (counter < N_CNT);
   assign cidx   = counter[IW-1:0];
   assign x_sel  = xbuf[cidx*W +: W];

`ifdef MVM_ZERO_SKIP_EN
   assign skip = fetch & cnt_ok & (x_sel == '0);
`else
   assign skip = 1'b0;
`endif

   // weight store; the non-blocking read below sees the pre-write row
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < N; r++)
            wmem[r] <= '0;
      end else if (prog_wt && (int'(wt_addr) < N)) begin
         wmem[wt_addr] <= wt_row;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xbuf      <= '0;
         x_q       <= '0;
         idx_q     <= '0;
         w_q       <= '0;
         out_vec   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (get_ready)
            xbuf <= in_vec;
         if (fetch && cnt_ok) begin
            x_q   <= x_sel;
            idx_q <= cidx;
         end
         if (rd_en)
            w_q <= wmem[idx_q];
         if (mvm_done)
            out_vec <= acc_flat;
         out_valid <= mvm_done;
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_lane
      mvm_mac_lane #(
         .W  (W),
         .AW (AW)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .calc   (calc),
         .up_sum (up_sum),
         .clr    (get_ready),
         .x_q    (x_q),
         .w_q    (w_q[j*W +: W]),
         .acc    (acc_flat[j*AW +: AW])
      );
   end

endmodule

// File: tb/tb_mvm_datapath.sv
// tb_mvm_datapath: drives the control-unit strobe sequence; a monitor scores out_vec on out_valid.
module tb_mvm_datapath;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = 3;
   localparam int AW = 18;
`ifdef MVM_ZERO_SKIP_EN
   localparam bit ZS = 1'b1;
`else
   localparam bit ZS = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            prog_wt, get_ready, fetch, rd_en, calc, up_sum, mvm_done;
   logic [1:0]      wt_addr;
   logic [N*W-1:0]  wt_row;
   logic [CW-1:0]   counter;
   logic [N*W-1:0]  in_vec;
   logic            skip;
   logic [N*AW-1:0] out_vec;
   logic            out_valid;

   int checks = 0;
   int errors = 0;
   logic [N*AW-1:0] sb_q [$];
   logic [N*AW-1:0] mon_e;
   logic            prev_valid = 1'b0;

   mvm_datapath #(.N(N), .W(W), .CW(CW), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .prog_wt   (prog_wt),
      .wt_addr   (wt_addr),
      .wt_row    (wt_row),
      .get_ready (get_ready),
      .fetch     (fetch),
      .rd_en     (rd_en),
      .calc      (calc),
      .up_sum    (up_sum),
      .counter   (counter),
      .mvm_done  (mvm_done),
      .skip      (skip),
      .in_vec    (in_vec),
      .out_vec   (out_vec),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor: one scoreboard entry per out_valid pulse
   always @(negedge clk) begin
      if (out_valid) begin
         check("out_valid_single_cycle", prev_valid, 0);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got pulse expected none");
         end else begin
            mon_e = sb_q.pop_front();
            for (int j = 0; j < N; j++)
               check($sformatf("y%0d", j), $signed(out_vec[j*AW +: AW]), $signed(mon_e[j*AW +: AW]));
         end
      end
      prev_valid <= out_valid;
   end

   task automatic idle();
      prog_wt = 0; get_ready = 0; fetch = 0; rd_en = 0; calc = 0; up_sum = 0; mvm_done = 0;
   endtask

   task automatic program_row(input int r, input logic [N*W-1:0] row);
      prog_wt = 1; wt_addr = 2'(r); wt_row = row;
      @(negedge clk);
      prog_wt = 0;
   endtask

   task automatic program_ramp();
      logic [N*W-1:0] row;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++)
            row[j*W +: W] = W'(i*4 + j);
         program_row(i, row);
      end
   endtask

   task automatic run_mvm(input string tag, input int x[N], input int y[N],
                          input bit rbw, input bit hold_chk, input int hold_val);
      logic [N*AW-1:0] e;
      logic [N*W-1:0]  row9;
      logic            sk;
      e = '0;
      for (int j = 0; j < N; j++) e[j*AW +: AW] = AW'(y[j]);
      for (int j = 0; j < N; j++) row9[j*W +: W] = 8'd9;
      sb_q.push_back(e);
      for (int i = 0; i < N; i++) in_vec[i*W +: W] = W'(x[i]);
      get_ready = 1;
      @(negedge clk);
      get_ready = 0;
      for (int i = 0; i < N; i++) begin
         fetch = 1; counter = CW'(i);
         #1;
         sk = skip;
         check($sformatf("%s_skip%0d", tag, i), sk, (ZS && x[i] == 0));
         @(negedge clk);
         fetch = 0;
         if (!sk) begin
            rd_en = 1;
            if (rbw && i == 0) begin
               prog_wt = 1; wt_addr = 2'd0; wt_row = row9;
            end
            @(negedge clk);
            rd_en = 0; prog_wt = 0;
            calc = 1;
            @(negedge clk);
            calc = 0; up_sum = 1;
            @(negedge clk);
            up_sum = 0;
         end
      end
      if (hold_chk)
         for (int j = 0; j < N; j++)
            check($sformatf("%s_hold%0d", tag, j), $signed(out_vec[j*AW +: AW]), hold_val);
      mvm_done = 1;
      @(negedge clk);
      mvm_done = 0;
      @(negedge clk);
   endtask

   initial begin
      logic [N*W-1:0] row;
      idle();
      reset = 1; wt_addr = '0; wt_row = '0; counter = '0; in_vec = '0;
      repeat (2) @(negedge clk);
      check("reset_out_vec", out_vec, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_skip", skip, 0);
      reset = 0;
      @(negedge clk);

      program_ramp();
      run_mvm("unit", '{1, 0, 0, 0}, '{0, 1, 2, 3}, 0, 0, 0);
      run_mvm("rbw_old", '{1, 0, 0, 0}, '{0, 1, 2, 3}, 1, 0, 0);
      run_mvm("rbw_new", '{1, 0, 0, 0}, '{9, 9, 9, 9}, 0, 0, 0);
      program_ramp();
      run_mvm("full", '{1, 2, 3, 4}, '{80, 90, 100, 110}, 0, 0, 0);
      run_mvm("zskip", '{0, 5, 0, 0}, '{20, 25, 30, 35}, 0, 0, 0);

      for (int j = 0; j < N; j++) row[j*W +: W] = 8'h80;
      for (int i = 0; i < N; i++) program_row(i, row);
      run_mvm("ext", '{-128, -128, -128, -128}, '{65536, 65536, 65536, 65536}, 0, 0, 0);

      program_ramp();
      run_mvm("b2b", '{1, 1, 1, 1}, '{24, 28, 32, 36}, 0, 1, 65536);

      // reset lands on the calc cycle of an in-flight MVM
      for (int i = 0; i < N; i++) in_vec[i*W +: W] = W'(i + 1);
      get_ready = 1; @(negedge clk); get_ready = 0;
      fetch = 1; counter = '0; @(negedge clk); fetch = 0;
      rd_en = 1; @(negedge clk); rd_en = 0;
      calc = 1; reset = 1; @(negedge clk); calc = 0; reset = 0;
      for (int j = 0; j < N; j++)
         check($sformatf("rst_y%0d", j), $signed(out_vec[j*AW +: AW]), 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_skip", skip, 0);
      run_mvm("rst_wt", '{1, 1, 1, 1}, '{0, 0, 0, 0}, 0, 0, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
